// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Stall/flush/forward control for a 5-stage RISC-V pipeline,
//               with a memory-wait FSM, timeout flag and perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic             LoadE,
  input  logic             PCSrcE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemWaitState,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCycles
);

  localparam int c_WCNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [c_WCNT_W-1:0] c_TIMEOUT = c_WCNT_W'(MEM_TIMEOUT);
  localparam logic [0:0] c_RUN  = 1'b0;
  localparam logic [0:0] c_WAIT = 1'b1;

  logic [0:0]          r_state;
  logic [0:0]          w_state_next;
  logic [c_WCNT_W-1:0] r_wcnt;
  logic [c_WCNT_W-1:0] w_wcnt_inc;
  logic                r_timeout;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [CNT_W-1:0]    r_flush_cnt;
  logic                w_mem_busy;
  logic                w_lw_stall;
  logic                w_wait_busy;

  assign w_mem_busy  = MemReqM & ~MemReadyM;
  assign w_lw_stall  = LoadE & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));
  assign w_wait_busy = (r_state == c_WAIT) & w_mem_busy;
  assign w_wcnt_inc  = r_wcnt + c_WCNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= c_RUN;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_RUN:   if (w_mem_busy) w_state_next = c_WAIT;
      c_WAIT:  if (MemReadyM | ~MemReqM) w_state_next = c_RUN;
      default: w_state_next = c_RUN;
    endcase
  end

  // Memory stall overrides everything; a redirect stays parked in frozen E.
  always_comb begin
    StallF = w_lw_stall;
    StallD = w_lw_stall;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = PCSrcE;
    FlushE = w_lw_stall | PCSrcE;
    FlushW = 1'b0;
    if (w_mem_busy) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushW = 1'b1;
    end

    ForwardAE = 2'b00;
    if (RegWriteM && RdM != 5'd0 && RdM == Rs1E)      ForwardAE = 2'b10;
    else if (RegWriteW && RdW != 5'd0 && RdW == Rs1E) ForwardAE = 2'b01;

    ForwardBE = 2'b00;
    if (RegWriteM && RdM != 5'd0 && RdM == Rs2E)      ForwardBE = 2'b10;
    else if (RegWriteW && RdW != 5'd0 && RdW == Rs2E) ForwardBE = 2'b01;

    MemWaitState = (r_state == c_WAIT);
    MemTimeout   = r_timeout;
    StallCycles  = r_stall_cnt;
    FlushCycles  = r_flush_cnt;
  end

  // Wait counter saturates at the timeout; the flag is sticky until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wcnt    <= '0;
      r_timeout <= 1'b0;
    end else if (w_wait_busy) begin
      if (r_wcnt != c_TIMEOUT) r_wcnt <= w_wcnt_inc;
      if (w_wcnt_inc == c_TIMEOUT) r_timeout <= 1'b1;
    end else begin
      r_wcnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (StallF && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (FlushD && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire
